// File: rtl/rv32_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM port, IF/ID handshake toward decode,
// redirect input from execute, and fetch status.
interface rv32_fetch_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic              id_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_fault;
  logic [31:0]       fetch_count;

  // fetch stage side
  modport master (
    output imem_addr,
    input  imem_data,
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_fault,
    output fetch_count
  );

  // ROM / decode / execute side
  modport slave (
    input  imem_addr,
    output imem_data,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready,
    output redirect_valid,
    output redirect_pc,
    input  fetch_fault,
    input  fetch_count
  );
endinterface

// File: rtl/rv32_fetch.sv
// rv32 instruction fetch stage: owns the PC, reads the combinational ROM and
// fills the IF/ID register. Redirects flush IF/ID and reload the PC; an
// illegal PC (misaligned or beyond the ROM) parks the stage in FAULT until a
// redirect to a legal target arrives.
module rv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic          clk,
  input  logic          rst,
  rv32_fetch_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  state_t      state;
  logic [31:0] pc;
  ifid_t       ifid;
  logic        ifid_vld;
  logic        fault;
  logic [31:0] count;

  logic pc_legal;
  logic redir_legal;
  logic xfer;
  logic advance;

  // Legal address: word aligned and inside the 2**ADDR_W word ROM.
  assign pc_legal    = (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0);
  assign redir_legal = (bus.redirect_pc[1:0] == 2'b00) &&
                       (bus.redirect_pc[31:ADDR_W+2] == '0);

  // Decode takes the IF/ID entry this cycle (also true when it is being flushed).
  assign xfer = ifid_vld & bus.id_ready;

  // A new fetch can land in IF/ID: slot empty or draining, no redirect, PC legal.
  assign advance = (state == RUN) && (!ifid_vld || bus.id_ready) &&
                   !bus.redirect_valid && pc_legal;

  // ROM address follows the PC in every state, so the ROM never sees X.
  assign bus.imem_addr   = pc[ADDR_W+1:2];
  assign bus.id_valid    = ifid_vld;
  assign bus.id_instr    = ifid.instr;
  assign bus.id_pc       = ifid.pc;
  assign bus.fetch_fault = fault;
  assign bus.fetch_count = count;

  // Fetch FSM, PC, IF/ID register, fault flag and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      ifid     <= '0;
      ifid_vld <= 1'b0;
      fault    <= 1'b0;
      count    <= '0;
    end else begin
      if (xfer) count <= count + 32'd1;

      case (state)
        BOOT: begin
          // One idle cycle out of reset; a redirect here still lands in RUN
          // and the target gets checked there.
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= RUN;
          end else if (pc_legal) begin
            state <= RUN;
          end else begin
            state <= FAULT;
            fault <= 1'b1;
          end
        end

        RUN: begin
          if (bus.redirect_valid) begin
            ifid_vld <= 1'b0;
            pc       <= bus.redirect_pc;
          end else if (!pc_legal) begin
            // No fetch from a bad PC; whatever already sits in IF/ID may drain.
            state <= FAULT;
            fault <= 1'b1;
            if (xfer) ifid_vld <= 1'b0;
          end else if (advance) begin
            ifid     <= '{instr: bus.imem_data, pc: pc};
            ifid_vld <= 1'b1;
            pc       <= pc + 32'd4;
          end
          // otherwise stalled: IF/ID and pc hold
        end

        FAULT: begin
          if (bus.redirect_valid) begin
            ifid_vld <= 1'b0;
            pc       <= bus.redirect_pc;
            if (redir_legal) begin
              state <= RUN;
              fault <= 1'b0;
            end
          end else if (xfer) begin
            ifid_vld <= 1'b0;
          end
        end

        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule
